// File: rtl/sipo_deser_if.sv
// Serial-in / word-out bundle between a serial link front end, the
// deserialiser and the word-wide consumer. The link side and the consumer
// side together form the master; the deserialiser is the slave.
interface sipo_deser_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH);

    logic             IN;
    logic             IN_EN;
    logic             CLR;
    logic             Q_READY;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic             OVERRUN;
    logic [CW-1:0]    BIT_CNT;

    modport master (
        output IN, IN_EN, CLR, Q_READY,
        input  Q, Q_VALID, OVERRUN, BIT_CNT
    );

    modport slave (
        input  IN, IN_EN, CLR, Q_READY,
        output Q, Q_VALID, OVERRUN, BIT_CNT
    );
endinterface

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser. Shifts one bit per IN_EN
// strobe, counts bits per word and hands each completed word to the consumer
// through a holding register with a valid/ready handshake. A word completing
// while the previous one is still unconsumed is dropped and flagged in the
// sticky OVERRUN bit. The interface instance must use the same WIDTH.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic         CLK,
    input  logic         RST,
    sipo_deser_if.slave  bus
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             overrun;

    logic shift;
    logic done;
    logic accept;

    // A bit is taken only when strobed and not cancelled by CLR; the word
    // completes on the strobe that carries its last bit.
    assign shift  = bus.IN_EN && !bus.CLR;
    assign done   = shift && (cnt == LAST);
    assign accept = q_valid && bus.Q_READY;

    // Next shift-register value including the bit arriving this cycle; this is
    // also the candidate word on completion.
    always_comb begin
        sr_next = sr;
        if (MSB_FIRST)
            sr_next = {sr[WIDTH-2:0], bus.IN};
        else
            sr_next = {bus.IN, sr[WIDTH-1:1]};
    end

    // Partial-word capture, bit counter and sticky overrun flag.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sr      <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (bus.CLR) begin
            sr      <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (bus.IN_EN) begin
            sr  <= sr_next;
            cnt <= done ? '0 : cnt + 1'b1;
            // Dropping a word leaves the counter and next word untouched.
            if (done && q_valid && !bus.Q_READY)
                overrun <= 1'b1;
        end
    end

    // Holding register and valid flag; a completion coinciding with an accept
    // reloads Q so a streaming consumer sees back-to-back words.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (done && (!q_valid || bus.Q_READY)) begin
            q       <= sr_next;
            q_valid <= 1'b1;
        end else if (accept) begin
            q_valid <= 1'b0;
        end
    end

    assign bus.Q       = q;
    assign bus.Q_VALID = q_valid;
    assign bus.OVERRUN = overrun;
    assign bus.BIT_CNT = cnt;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser at WIDTH=8. Two instances share the same
// stimulus: one LSB-first, one MSB-first, so every word also exercises the
// reversed bit order.
module tb_sipo_deser;
    logic CLK = 1'b0;
    logic RST;
    logic in_b, in_en, clr, q_ready;

    int total = 0;
    int bad   = 0;

    sipo_deser_if #(.WIDTH(8)) bus0 ();
    sipo_deser_if #(.WIDTH(8)) bus1 ();

    assign bus0.IN = in_b;  assign bus0.IN_EN = in_en;
    assign bus0.CLR = clr;  assign bus0.Q_READY = q_ready;
    assign bus1.IN = in_b;  assign bus1.IN_EN = in_en;
    assign bus1.CLR = clr;  assign bus1.Q_READY = q_ready;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.CLK(CLK), .RST(RST), .bus(bus0));
    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.CLK(CLK), .RST(RST), .bus(bus1));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, outputs then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Feed n bits of w starting at bit 0; leaves IN_EN asserted.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            in_b  = w[i];
            in_en = 1'b1;
            tick();
        end
    endtask

    initial begin
        RST = 1'b0; in_b = 1'b0; in_en = 1'b0; clr = 1'b0; q_ready = 1'b0;
        tick(); tick();
        check("rst_q",     bus0.Q, 8'h00);
        check("rst_valid", bus0.Q_VALID, 1'b0);
        check("rst_cnt",   bus0.BIT_CNT, 3'd0);
        check("rst_ovr",   bus0.OVERRUN, 1'b0);
        check("rst_q_msb", bus1.Q, 8'h00);
        RST = 1'b1;

        // Case 1: LSB-first A5, ready held high.
        q_ready = 1'b1;
        send_bits(8'hA5, 3);
        check("c1_cnt3", bus0.BIT_CNT, 3'd3);
        send_bits(8'hA5 >> 3, 5);
        check("c1_q",     bus0.Q, 8'hA5);
        check("c1_valid", bus0.Q_VALID, 1'b1);
        check("c1_cnt0",  bus0.BIT_CNT, 3'd0);
        check("c1_q_msb", bus1.Q, 8'hA5);
        in_en = 1'b0;
        tick();
        check("c1_valid_pulse", bus0.Q_VALID, 1'b0);
        check("c1_q_hold",      bus0.Q, 8'hA5);

        // Case 2: same bits with IN_EN gaps; counter holds during gaps.
        for (int i = 0; i < 8; i++) begin
            in_en = 1'b0;
            in_b  = ~in_b;
            tick(); tick();
            if (i == 4) check("c2_cnt_gap", bus1.BIT_CNT, 3'd4);
            in_b  = (8'hA5 >> i) & 8'h01;
            in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        check("c2_q_msb",     bus1.Q, 8'hA5);
        check("c2_valid_msb", bus1.Q_VALID, 1'b1);
        check("c2_q_lsb",     bus0.Q, 8'hA5);
        tick();
        check("c2_valid_clr", bus1.Q_VALID, 1'b0);

        // Case 3: consumer stalled, second word overruns.
        q_ready = 1'b0;
        send_bits(8'h3C, 8);
        check("c3_q1",     bus0.Q, 8'h3C);
        check("c3_valid1", bus0.Q_VALID, 1'b1);
        check("c3_ovr0",   bus0.OVERRUN, 1'b0);
        send_bits(8'hFF, 8);
        in_en = 1'b0;
        check("c3_q_kept", bus0.Q, 8'h3C);
        check("c3_ovr1",   bus0.OVERRUN, 1'b1);
        check("c3_cnt",    bus0.BIT_CNT, 3'd0);
        check("c3_valid2", bus0.Q_VALID, 1'b1);
        q_ready = 1'b1;
        tick();
        check("c3_valid_acc", bus0.Q_VALID, 1'b0);
        check("c3_ovr_sticky", bus0.OVERRUN, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("c3_ovr_clr", bus0.OVERRUN, 1'b0);

        // Case 4: three words streamed back to back with ready held.
        send_bits(8'h01, 8);
        check("c4_q01",   bus0.Q, 8'h01);
        check("c4_q01_m", bus1.Q, 8'h80);
        check("c4_v01",   bus0.Q_VALID, 1'b1);
        send_bits(8'h80, 1);
        check("c4_v_drop", bus0.Q_VALID, 1'b0);
        send_bits(8'h80 >> 1, 7);
        check("c4_q80",   bus0.Q, 8'h80);
        check("c4_q80_m", bus1.Q, 8'h01);
        check("c4_v80",   bus0.Q_VALID, 1'b1);
        send_bits(8'hFF, 8);
        check("c4_qff",   bus0.Q, 8'hFF);
        check("c4_vff",   bus0.Q_VALID, 1'b1);
        check("c4_ovr",   bus0.OVERRUN, 1'b0);
        in_en = 1'b0;
        tick();
        check("c4_v_end", bus0.Q_VALID, 1'b0);

        // Case 5: accept on the completion cycle of the next word.
        q_ready = 1'b0;
        send_bits(8'h5A, 8);
        send_bits(8'hC3, 7);
        check("c5_q_stable", bus0.Q, 8'h5A);
        check("c5_v_wait",   bus0.Q_VALID, 1'b1);
        q_ready = 1'b1;
        send_bits(8'hC3 >> 7, 1);
        in_en = 1'b0;
        check("c5_q_new",  bus0.Q, 8'hC3);
        check("c5_v_kept", bus0.Q_VALID, 1'b1);
        check("c5_ovr",    bus0.OVERRUN, 1'b0);
        tick();
        check("c5_v_end",  bus0.Q_VALID, 1'b0);

        // Case 6: CLR and reset mid-word, then a fresh word.
        send_bits(8'hFF, 5);
        check("c6_cnt5", bus0.BIT_CNT, 3'd5);
        clr = 1'b1; in_b = 1'b1; in_en = 1'b1;
        tick();
        clr = 1'b0; in_en = 1'b0;
        check("c6_cnt_clr", bus0.BIT_CNT, 3'd0);
        send_bits(8'h96, 8);
        in_en = 1'b0;
        check("c6_q96", bus0.Q, 8'h96);
        send_bits(8'hFF, 5);
        RST = 1'b0;
        tick();
        RST = 1'b1; in_en = 1'b0;
        check("c6_rst_q",   bus0.Q, 8'h00);
        check("c6_rst_v",   bus0.Q_VALID, 1'b0);
        check("c6_rst_cnt", bus0.BIT_CNT, 3'd0);
        send_bits(8'h6B, 8);
        in_en = 1'b0;
        check("c6_q6b",   bus0.Q, 8'h6B);
        check("c6_q6b_m", bus1.Q, 8'hD6);
        check("c6_v",     bus0.Q_VALID, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
